uart_prog_loader: RTL and testbench

- Serial program loader feeding the instruction-RAM write port of the fetch unit.
- Receives 8N1 UART bytes from the host on `rx`.
- Per valid byte: presents it on `buffer` with a one-cycle `uart_done` strobe and the target byte address on `data_addr`, then advances the address.
- Runs on the RAM-side clock; the fetch unit consumes `uart_done`/`buffer`/`data_addr` directly as byte-write enable, data and address.

---
 rtl/uart_prog_loader.sv | 113 +++++++++++
 tb/tb_uart_prog_loader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// UART 8N1 byte receiver that streams received bytes into an instruction RAM
// write port, supplying the byte, a write strobe and an auto-incrementing address.
module uart_prog_loader #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic              addr_clr,
  output logic              uart_done,
  output logic [7:0]        buffer,
  output logic [ADDR_W-1:0] data_addr,
  output logic              frame_err,
  output logic              busy
);

  // CPB must be at least 4 so the half-bit count is non-zero.
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(CPB + 1);
  localparam logic [CW-1:0] CNT_BIT  = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2 - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          rx_m;
  logic          rx_s;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      uart_done <= 1'b0;
      frame_err <= 1'b0;
      buffer    <= 8'h00;
      data_addr <= '0;
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      uart_done <= 1'b0;
      frame_err <= 1'b0;

      // Address advances the cycle after each strobe; a clear always wins.
      if (addr_clr)
        data_addr <= '0;
      else if (uart_done)
        data_addr <= data_addr + 1'b1;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_BIT) begin
            cnt     <= '0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7)
              state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_BIT) begin
            cnt   <= '0;
            state <= IDLE;
            if (rx_s) begin
              buffer    <= shift;
              uart_done <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data bits arrive LSB-first, so shift in from the top.
  always_ff @(posedge clk) begin
    if (state == DATA && cnt == CNT_BIT)
      shift <= {rx_s, shift[7:1]};
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: two instances (16-bit and 4-bit address)
// share one serial line so address wrap is observable alongside normal traffic.
module tb_uart_prog_loader;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;
  localparam int CPB      = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic        addr_clr = 1'b0;
  logic        uart_done, frame_err, busy;
  logic [7:0]  buffer;
  logic [15:0] data_addr;
  logic        uart_done4, frame_err4, busy4;
  logic [7:0]  buffer4;
  logic [3:0]  data_addr4;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ferr   = 0;
  int q_byte[$];
  int q_addr[$];
  int q_addr4[$];

  uart_prog_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .rx(rx), .addr_clr(addr_clr),
    .uart_done(uart_done), .buffer(buffer), .data_addr(data_addr),
    .frame_err(frame_err), .busy(busy)
  );

  uart_prog_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDR_W(4)) dut4 (
    .clk(clk), .rst(rst), .rx(rx), .addr_clr(addr_clr),
    .uart_done(uart_done4), .buffer(buffer4), .data_addr(data_addr4),
    .frame_err(frame_err4), .busy(busy4)
  );

  always #5 clk = ~clk;

  // Record every strobe and framing error, sampled mid-cycle.
  always @(negedge clk) begin
    if (uart_done) begin
      q_byte.push_back(int'(buffer));
      q_addr.push_back(int'(data_addr));
    end
    if (uart_done4) q_addr4.push_back(int'(data_addr4));
    if (frame_err) n_ferr++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Each bit call starts just after a rising edge and ends just after one.
  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int base, base4, ferr0, lat;
  bit found;

  initial begin
    do_reset();
    @(negedge clk);
    check_val("rst_uart_done", uart_done, 0);
    check_val("rst_frame_err", frame_err, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_buffer", buffer, 8'h00);
    check_val("rst_data_addr", data_addr, 0);
    @(posedge clk); #1;

    // Single byte
    base = q_byte.size();
    send_frame(8'hA5, 1'b1);
    idle(2 * CPB);
    check_val("a5_count", q_byte.size() - base, 1);
    check_val("a5_byte", qget(q_byte, base), 8'hA5);
    check_val("a5_addr", qget(q_addr, base), 0);
    check_val("a5_addr_after", data_addr, 1);
    check_val("a5_no_ferr", n_ferr, 0);

    // Back-to-back frames from a fresh address
    do_reset();
    base = q_byte.size();
    send_frame(8'h13, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(2 * CPB);
    check_val("b2b_count", q_byte.size() - base, 3);
    check_val("b2b_byte0", qget(q_byte, base), 8'h13);
    check_val("b2b_byte1", qget(q_byte, base + 1), 8'h00);
    check_val("b2b_byte2", qget(q_byte, base + 2), 8'hFF);
    check_val("b2b_addr0", qget(q_addr, base), 0);
    check_val("b2b_addr1", qget(q_addr, base + 1), 1);
    check_val("b2b_addr2", qget(q_addr, base + 2), 2);
    check_val("b2b_addr_final", data_addr, 3);

    // Short low glitch is rejected at the mid start-bit check
    base = q_byte.size();
    ferr0 = n_ferr;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("glitch_busy_high", busy, 1);
    rx = 1'b1;
    repeat (CPB / 2 + 1) @(posedge clk);
    @(negedge clk);
    check_val("glitch_busy_low", busy, 0);
    idle(2 * CPB);
    check_val("glitch_no_done", q_byte.size() - base, 0);
    check_val("glitch_no_ferr", n_ferr - ferr0, 0);

    // Low stop bit: framing error, nothing written
    base = q_byte.size();
    ferr0 = n_ferr;
    send_frame(8'h55, 1'b0);
    idle(3 * CPB);
    check_val("ferr_count", n_ferr - ferr0, 1);
    check_val("ferr_no_done", q_byte.size() - base, 0);
    check_val("ferr_buffer_held", buffer, 8'hFF);
    check_val("ferr_addr_held", data_addr, 3);
    send_frame(8'h3C, 1'b1);
    idle(2 * CPB);
    check_val("after_ferr_byte", qget(q_byte, base), 8'h3C);
    check_val("after_ferr_addr", qget(q_addr, base), 3);
    check_val("after_ferr_addr_next", data_addr, 4);

    // addr_clr during the strobe cycle
    base = q_byte.size();
    found = 0;
    fork
      send_frame(8'h77, 1'b1);
      begin
        for (int i = 0; i < 200 && !found; i++) begin
          @(negedge clk);
          if (uart_done) found = 1;
        end
        if (found) begin
          addr_clr = 1'b1;
          @(posedge clk); #1;
          addr_clr = 1'b0;
        end
      end
    join
    check_val("clr_strobe_seen", found, 1);
    @(negedge clk);
    check_val("clr_byte", qget(q_byte, base), 8'h77);
    check_val("clr_old_addr", qget(q_addr, base), 4);
    check_val("clr_addr_zero", data_addr, 0);
    check_val("clr_addr4_zero", data_addr4, 0);
    @(posedge clk); #1;

    // Reset in the middle of data bit 4, then a timed frame
    base = q_byte.size();
    ferr0 = n_ferr;
    rx = 1'b0;
    repeat (CPB + 4 * CPB + CPB / 2) @(posedge clk);
    #1;
    rx = 1'b1;
    do_reset();
    idle(2 * CPB);
    lat = 0;
    fork
      send_frame(8'h81, 1'b1);
      begin
        for (int i = 1; i <= 200 && lat == 0; i++) begin
          @(negedge clk);
          if (uart_done) lat = i;
        end
      end
    join
    idle(2 * CPB);
    check_val("rst_abort_count", q_byte.size() - base, 1);
    check_val("rst_abort_no_ferr", n_ferr - ferr0, 0);
    check_val("rst_81_byte", qget(q_byte, base), 8'h81);
    check_val("rst_81_addr", qget(q_addr, base), 0);
    // rx_s goes low in the 3rd cycle after the line falls (two sync flops).
    check_val("latency", lat, 3 + CPB / 2 + 9 * CPB + 1);

    // 17 bytes from reset: 4-bit address wraps on the 17th
    do_reset();
    base = q_byte.size();
    base4 = q_addr4.size();
    for (int k = 0; k < 17; k++) send_frame(8'(8'h40 + k), 1'b1);
    idle(2 * CPB);
    check_val("wrap_count", q_addr4.size() - base4, 17);
    check_val("wrap_addr4_15", qget(q_addr4, base4 + 15), 15);
    check_val("wrap_addr4_16", qget(q_addr4, base4 + 16), 0);
    check_val("wrap_addr16_16", qget(q_addr, base + 16), 16);
    check_val("wrap_byte_16", qget(q_byte, base + 16), 8'h50);
    check_val("wrap_addr4_final", data_addr4, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
